// File: rtl/pipe_mdu_ctrl_if.sv
// Pipeline-side bundle of the iterative multiply/divide unit.
// estart is a request held by EXE; estall is the stall/busy reply, and hi/lo are valid in the mdone cycle.
interface pipe_mdu_ctrl_if;
  logic        estart;
  logic        eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        eflush;
  logic        estall;
  logic        mdone;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output estart, eop, ea, eb, eflush,
    input  estall, mdone, hi, lo
  );

  modport slave (
    input  estart, eop, ea, eb, eflush,
    output estall, mdone, hi, lo
  );
endinterface

// File: rtl/pipe_mdu_ctrl.sv
// Iterative 32-bit unsigned multiply / restoring divide unit that stalls the pipeline while busy.
// One shared 64-bit accumulator holds product-in-progress or remainder:quotient.
module pipe_mdu_ctrl (
  input  logic        clock,
  input  logic        reset,
  pipe_mdu_ctrl_if.slave bus,
  output logic [1:0]  dbg_state,
  output logic [4:0]  dbg_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_step;
  logic [31:0] opnd;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        accept;
  logic        busy;
  logic        finish;
  logic        div0;
  logic [32:0] mul_sum;
  logic [31:0] rem_sub;
  logic        rem_ge;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state == S_MUL) || (state == S_DIV);
    accept     = bus.estart && !bus.eflush && ((state == S_IDLE) || (state == S_DONE));
    finish     = busy && !bus.eflush && (cnt == 5'd31);
    div0       = accept && bus.eop && (bus.eb == 32'd0);
    bus.estall = accept || busy;
    bus.mdone  = (state == S_DONE);
    if (bus.eflush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (!bus.eop)     state_nx = S_MUL;
            else if (div0)    state_nx = S_DONE;
            else              state_nx = S_DIV;
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == 5'd31) state_nx = S_DONE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Multiply adds the multiplicand into the top half, then shifts right; the multiplier drains out of the bottom.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    rem_ge   = (acc[63:31] >= {1'b0, opnd});
    rem_sub  = acc[62:31] - opnd;
    acc_step = {mul_sum, acc[31:1]};
    if (state == S_DIV) begin
      acc_step = rem_ge ? {rem_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= 5'd0;
      acc  <= 64'd0;
      opnd <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (accept) begin
      cnt  <= 5'd0;
      acc  <= {32'd0, (bus.eop ? bus.ea : bus.eb)};
      opnd <= bus.eop ? bus.eb : bus.ea;
      if (div0) begin
        hi_q <= bus.ea;
        lo_q <= 32'hFFFF_FFFF;
      end
    end else if (busy && !bus.eflush) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
      if (finish) begin
        hi_q <= acc_step[63:32];
        lo_q <= acc_step[31:0];
      end
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: doc/pipe_mdu_ctrl.md
PIPE_MDU_CTRL -- requirements
Module: pipe_mdu_ctrl

Interface
REQ-001 Parameter: none; width fixed at 32 bits, iteration count fixed at 32.
REQ-002 clock  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 estart  in  1  EXE-stage request to begin a multiply/divide this cycle.
REQ-005 eop  in  1  0 = unsigned multiply, 1 = unsigned divide; sampled only with an accepted estart.
REQ-006 ea  in  32  operand A (multiplicand or dividend); sampled only with an accepted estart.
REQ-007 eb  in  32  operand B (multiplier or divisor); sampled only with an accepted estart.
REQ-008 eflush  in  1  abort any operation in progress (branch or exception flush).
REQ-009 estall  out  1  freeze the IF/ID/EXE pipeline registers.
REQ-010 mdone  out  1  one-cycle pulse; hi/lo have just been updated.
REQ-011 hi  out  32  product[63:32] or remainder.
REQ-012 lo  out  32  product[31:0] or quotient.

Function
REQ-013 The block SHALL implement the states IDLE, MUL, DIV and DONE, plus a 5-bit iteration counter.
REQ-014 An estart in IDLE or DONE with eflush=0 SHALL be accepted.
- It latches ea, eb and eop, and clears the counter.
- Next state is MUL when eop=0, DIV when eop=1 and eb!=0, DONE when eop=1 and eb=0.
REQ-015 estart in MUL or DIV SHALL be ignored.
REQ-016 estall SHALL equal (estart & (IDLE|DONE) & ~eflush) | MUL | DIV.
- The pipeline therefore stalls in the accept cycle and every iteration cycle, and is released in DONE.
REQ-017 MUL SHALL perform one shift-add step per cycle on a 64-bit accumulator and increment the counter.
REQ-018 DIV SHALL perform one restoring shift-subtract step per cycle on a 64-bit remainder/quotient register and increment the counter.
REQ-019 When the counter equals 31 in MUL or DIV, the block SHALL write hi/lo on that edge and go to DONE.
- Total: accept at cycle T; iterations T+1..T+32; mdone=1 and estall=0 at T+33.
REQ-020 Multiply results SHALL be hi = product[63:32] and lo = product[31:0], unsigned.
REQ-021 Divide results SHALL be lo = floor(ea/eb) and hi = ea mod eb, unsigned.
REQ-022 Divide by zero SHALL complete in one cycle.
- Accept at T, DONE at T+1, with hi = ea and lo = 32'hFFFFFFFF.
REQ-023 DONE SHALL last one cycle and then return to IDLE, or start a new operation if estart=1 per REQ-014 (back-to-back).
REQ-024 eflush in any state SHALL force IDLE on the next edge.
- hi/lo SHALL NOT change and mdone SHALL NOT pulse.
- eflush takes priority over estart and over a final iteration.
REQ-025 hi and lo SHALL change only on the edge that enters DONE, or on reset.
REQ-026 mdone SHALL be 1 exactly when the state is DONE.

Reset
REQ-027 reset SHALL have priority over all other inputs.
REQ-028 After reset the block SHALL be in state IDLE with counter = 0, hi = 0, lo = 0, mdone = 0, and estall = 0 (with estart=0).
REQ-029 reset asserted mid-operation SHALL discard the operation with no mdone pulse; outputs follow REQ-028.

Verification
REQ-030 Multiply: estart, eop=0, ea=7, eb=6 at T -> estall=1 for T..T+32; at T+33 mdone=1, estall=0, hi=0, lo=42.
REQ-031 Multiply: ea=eb=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 at T+33.
REQ-032 Divide: eop=1, ea=100, eb=7 -> lo=14, hi=2 at T+33; then ea=5, eb=0 -> mdone and hi=5, lo=32'hFFFFFFFF one cycle after accept.
REQ-033 Flush: eflush=1 at T+10 of a multiply -> IDLE at T+11, estall=0, no mdone, hi/lo keep their prior values; the same test with reset -> hi=lo=0.
REQ-034 Back-to-back: estart held in the DONE cycle of 3*4 -> lo=12 reported, the new op is accepted in that cycle, and estall is high in that cycle per REQ-016.
REQ-035 Ignored start: estart toggled during MUL -> the result is unaffected and the latency is still 33 cycles.
